fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, meaning PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0800, meaning instruction word inserted into IF/ID on a flush or bubble.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 next_pc  input  16  redirect target from decode; valid only when if_flush=1.
REQ-006 if_flush  input  1  redirect request from decode (taken branch or jump).
REQ-007 pcWriteEn  input  1  PC update enable from decode hazard unit; 0 means stall.
REQ-008 IFIDWriteEn  input  1  IF/ID register write enable from decode hazard unit; 0 means hold.
REQ-009 imem_addr  output  16  instruction memory address; equals the current PC.
REQ-010 imem_rd  output  1  instruction memory read request.
REQ-011 imem_data  input  16  instruction word, valid when imem_done=1.
REQ-012 imem_done  input  1  read complete this cycle.
REQ-013 imem_stall  input  1  memory busy; the request must be held.
REQ-014 instr  output  16  IF/ID instruction word.
REQ-015 pc  output  16  IF/ID PC of instr.
REQ-016 pc_plus_two  output  16  IF/ID pc+2, modulo 2^16.
REQ-017 ifid_valid  output  1  instr holds a real fetched instruction, not an inserted NOP.
REQ-018 halted  output  1  a halt instruction (opcode 5'b00000) has been fetched and fetching has stopped.

Function
REQ-019 The block shall contain three states: FETCH (request outstanding or issuable), WAIT (memory stalled), HALTED.
REQ-020 In FETCH and WAIT, imem_rd shall be 1 and imem_addr shall equal PC. In HALTED, imem_rd shall be 0.
REQ-021 FETCH -> WAIT when imem_stall=1 and imem_done=0; WAIT -> FETCH when imem_done=1.
REQ-022 A completed fetch is a cycle with imem_done=1. With a zero-wait memory (done in the request cycle), throughput shall be one instruction per cycle.
REQ-023 On a completed fetch with pcWriteEn=1, IFIDWriteEn=1 and if_flush=0:
  - PC <= PC+2;
  - IF/ID <= {imem_data, PC, PC+2};
  - ifid_valid <= 1.
REQ-024 Stall (pcWriteEn=0 or IFIDWriteEn=0, with if_flush=0): PC and IF/ID shall hold; the completed word shall be discarded and refetched from the same PC next cycle.
REQ-025 if_flush=1 shall have priority over stall and over a completed fetch:
  - PC <= next_pc;
  - instr <= NOP_INSTR;
  - ifid_valid <= 0;
  - any in-flight word for the old PC shall be discarded.
REQ-026 if_flush=1 while in WAIT: the target shall be recorded. When imem_done arrives, the returned word shall be dropped, PC shall already equal the target, and the state shall return to FETCH with no extra cycle.
REQ-027 A cycle in WAIT with if_flush=0 and IFIDWriteEn=1 shall load IF/ID with NOP_INSTR and ifid_valid=0 (bubble).
REQ-028 A completed fetch of opcode 5'b00000 with REQ-023 conditions shall enter IF/ID normally, leave PC at the halt address, set halted=1 and move to HALTED.
REQ-029 HALTED shall persist until rst. if_flush in HALTED shall have no effect (the halt is architecturally final).
REQ-030 PC+2 shall wrap: 16'hFFFE + 2 = 16'h0000. next_pc shall be used unmodified (no alignment).

Reset
REQ-031 When rst=1 at a clock edge, the block shall set:
  - PC <= RESET_PC;
  - instr <= NOP_INSTR;
  - pc <= 0, pc_plus_two <= 0;
  - ifid_valid <= 0, halted <= 0;
  - state <= FETCH;
  - any recorded redirect cleared.
REQ-032 rst shall override every other input in the same cycle, including mid-WAIT and in HALTED. Memory data completing in the rst cycle shall be discarded.

Verification
REQ-033 Zero-wait memory returns 16'h4001,16'h4002,16'h4003 -> IF/ID pc 0,2,4 on consecutive cycles; pc_plus_two 2,4,6; ifid_valid=1.
REQ-034 Word at PC=4 returned with pcWriteEn=IFIDWriteEn=0 for 2 cycles -> IF/ID unchanged and imem_addr=4 for 2 cycles; then pc=4 enters IF/ID.
REQ-035 if_flush=1, next_pc=16'h0100 with a completed fetch at PC=6 -> instr=16'h0800, ifid_valid=0; next cycle imem_addr=16'h0100.
REQ-036 imem_stall=1 for 3 cycles at PC=8 with if_flush/next_pc=16'h0020 in the 2nd cycle -> 3 NOP bubbles; word for PC=8 dropped; next request at 16'h0020.
REQ-037 Fetch of 16'h0000 at PC=16'h000A -> halted=1, imem_rd=0 thereafter, IF/ID pc=16'h000A; a later if_flush is ignored; rst returns PC to 0.
REQ-038 PC=16'hFFFE with completed fetch -> pc_plus_two=16'h0000 and next imem_addr=16'h0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch FSM (FETCH/WAIT/HALTED) and the IF/ID pipeline register.
// Flushes always win over hazard stalls and completed fetches.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] next_pc,
    input  logic        if_flush,
    input  logic        pcWriteEn,
    input  logic        IFIDWriteEn,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        imem_stall,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic [15:0] pc_plus_two,
    output logic        ifid_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic        redir_q;
    logic        rd_q;
    logic [15:0] instr_q;
    logic [15:0] ifpc_q;
    logic [15:0] ifppt_q;
    logic        valid_q;
    logic        halted_q;

    logic [15:0] pc_inc_s;
    logic        accept_s;

    function automatic logic is_halt(input logic [15:0] word);
        return (word[15:11] == 5'b00000);
    endfunction

    assign pc_inc_s = pc_q + 16'd2;
    assign accept_s = pcWriteEn & IFIDWriteEn;

    assign imem_addr   = pc_q;
    assign imem_rd     = rd_q;
    assign instr       = instr_q;
    assign pc          = ifpc_q;
    assign pc_plus_two = ifppt_q;
    assign ifid_valid  = valid_q;
    assign halted      = halted_q;

    // Fetch FSM, PC and IF/ID register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            redir_q  <= 1'b0;
            rd_q     <= 1'b1;
            instr_q  <= NOP_INSTR;
            ifpc_q   <= 16'h0000;
            ifppt_q  <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH, S_WAIT: begin
                    rd_q <= 1'b1;
                    if (if_flush) begin
                        pc_q    <= next_pc;
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        // A request still pending at the memory returns a stale word later; remember to drop it.
                        if (!imem_done && (imem_stall || (state_q == S_WAIT))) begin
                            state_q <= S_WAIT;
                            redir_q <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            redir_q <= 1'b0;
                        end
                    end else if (imem_done) begin
                        state_q <= S_FETCH;
                        redir_q <= 1'b0;
                        if (redir_q) begin
                            if (IFIDWriteEn) begin
                                instr_q <= NOP_INSTR;
                                valid_q <= 1'b0;
                            end else begin
                                valid_q <= valid_q;
                            end
                        end else if (accept_s) begin
                            instr_q <= imem_data;
                            ifpc_q  <= pc_q;
                            ifppt_q <= pc_inc_s;
                            valid_q <= 1'b1;
                            if (is_halt(imem_data)) begin
                                halted_q <= 1'b1;
                                rd_q     <= 1'b0;
                                state_q  <= S_HALTED;
                            end else begin
                                pc_q <= pc_inc_s;
                            end
                        end else begin
                            pc_q <= pc_q;
                        end
                    end else if (state_q == S_WAIT) begin
                        if (IFIDWriteEn) begin
                            instr_q <= NOP_INSTR;
                            valid_q <= 1'b0;
                        end else begin
                            valid_q <= valid_q;
                        end
                    end else if (imem_stall) begin
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    rd_q     <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= S_FETCH;
                    rd_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each step drives one cycle of stimulus, queues the expected
// post-edge outputs, and compares them after the clock edge.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] next_pc;
    logic        if_flush;
    logic        pcWriteEn;
    logic        IFIDWriteEn;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_done;
    logic        imem_stall;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_plus_two;
    logic        ifid_valid;
    logic        halted;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] ppt;
        logic        valid;
        logic        halted;
        logic [15:0] addr;
        logic        rd;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   fail_cnt  = 0;
    int   step_idx  = 0;

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .if_flush(if_flush),
        .pcWriteEn(pcWriteEn), .IFIDWriteEn(IFIDWriteEn),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
        .imem_done(imem_done), .imem_stall(imem_stall),
        .instr(instr), .pc(pc), .pc_plus_two(pc_plus_two),
        .ifid_valid(ifid_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] i, input logic [15:0] p, input logic [15:0] pp,
                                input logic v, input logic h, input logic [15:0] a, input logic r);
        exp_t e;
        e.instr = i; e.pc = p; e.ppt = pp; e.valid = v; e.halted = h; e.addr = a; e.rd = r;
        return e;
    endfunction

    task automatic step(input logic r, input logic fl, input logic [15:0] npc, input logic pwe,
                        input logic iwe, input logic dn, input logic st, input logic [15:0] data,
                        input exp_t e);
        exp_t got_e;
        rst = r; if_flush = fl; next_pc = npc; pcWriteEn = pwe; IFIDWriteEn = iwe;
        imem_done = dn; imem_stall = st; imem_data = data;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb_q.pop_front();
        check_eq($sformatf("s%0d.instr", step_idx), instr, got_e.instr);
        check_eq($sformatf("s%0d.pc", step_idx), pc, got_e.pc);
        check_eq($sformatf("s%0d.pc_plus_two", step_idx), pc_plus_two, got_e.ppt);
        check_eq($sformatf("s%0d.ifid_valid", step_idx), {15'd0, ifid_valid}, {15'd0, got_e.valid});
        check_eq($sformatf("s%0d.halted", step_idx), {15'd0, halted}, {15'd0, got_e.halted});
        check_eq($sformatf("s%0d.imem_addr", step_idx), imem_addr, got_e.addr);
        check_eq($sformatf("s%0d.imem_rd", step_idx), {15'd0, imem_rd}, {15'd0, got_e.rd});
        step_idx++;
    endtask

    initial begin
        // reset, with a completing memory word that must be ignored
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4001, mk(NOP, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1));
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4001, mk(NOP, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1));
        // zero-wait streaming
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4001, mk(16'h4001, 16'h0000, 16'h0002, 1'b1, 1'b0, 16'h0002, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4002, mk(16'h4002, 16'h0002, 16'h0004, 1'b1, 1'b0, 16'h0004, 1'b1));
        // hazard stall at PC=4 for two cycles, then accept
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4003, mk(16'h4002, 16'h0002, 16'h0004, 1'b1, 1'b0, 16'h0004, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4003, mk(16'h4002, 16'h0002, 16'h0004, 1'b1, 1'b0, 16'h0004, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4003, mk(16'h4003, 16'h0004, 16'h0006, 1'b1, 1'b0, 16'h0006, 1'b1));
        // flush beats a completed fetch at PC=6
        step(1'b0, 1'b1, 16'h0100, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4004, mk(NOP, 16'h0004, 16'h0006, 1'b0, 1'b0, 16'h0100, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4005, mk(16'h4005, 16'h0100, 16'h0102, 1'b1, 1'b0, 16'h0102, 1'b1));
        step(1'b0, 1'b1, 16'h0006, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4099, mk(NOP, 16'h0100, 16'h0102, 1'b0, 1'b0, 16'h0006, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4008, mk(16'h4008, 16'h0006, 16'h0008, 1'b1, 1'b0, 16'h0008, 1'b1));
        // memory stall at PC=8 with a redirect during the wait; stale word dropped
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, mk(16'h4008, 16'h0006, 16'h0008, 1'b1, 1'b0, 16'h0008, 1'b1));
        step(1'b0, 1'b1, 16'h0020, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, mk(NOP, 16'h0006, 16'h0008, 1'b0, 1'b0, 16'h0020, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, mk(NOP, 16'h0006, 16'h0008, 1'b0, 1'b0, 16'h0020, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4006, mk(NOP, 16'h0006, 16'h0008, 1'b0, 1'b0, 16'h0020, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4007, mk(16'h4007, 16'h0020, 16'h0022, 1'b1, 1'b0, 16'h0022, 1'b1));
        // plain memory stall: bubble in WAIT, then the word is accepted
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, mk(16'h4007, 16'h0020, 16'h0022, 1'b1, 1'b0, 16'h0022, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, mk(NOP, 16'h0020, 16'h0022, 1'b0, 1'b0, 16'h0022, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4009, mk(16'h4009, 16'h0022, 16'h0024, 1'b1, 1'b0, 16'h0024, 1'b1));
        // PC wrap at 16'hFFFE
        step(1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, mk(NOP, 16'h0022, 16'h0024, 1'b0, 1'b0, 16'hFFFE, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h400A, mk(16'h400A, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1));
        // reset mid-WAIT with a recorded redirect; redirect must not survive
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, mk(16'h400A, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1));
        step(1'b0, 1'b1, 16'h0030, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, mk(NOP, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 16'h0030, 1'b1));
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, mk(NOP, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4001, mk(16'h4001, 16'h0000, 16'h0002, 1'b1, 1'b0, 16'h0002, 1'b1));
        // halt fetched at PC=16'h000A; later flush ignored; reset recovers
        step(1'b0, 1'b1, 16'h000A, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, mk(NOP, 16'h0000, 16'h0002, 1'b0, 1'b0, 16'h000A, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, mk(16'h0000, 16'h000A, 16'h000C, 1'b1, 1'b1, 16'h000A, 1'b0));
        step(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4000, mk(16'h0000, 16'h000A, 16'h000C, 1'b1, 1'b1, 16'h000A, 1'b0));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h0000, 16'h000A, 16'h000C, 1'b1, 1'b1, 16'h000A, 1'b0));
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4000, mk(NOP, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1));
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4001, mk(16'h4001, 16'h0000, 16'h0002, 1'b1, 1'b0, 16'h0002, 1'b1));

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
